// File: rtl/wrr_packet_arbiter_if.sv
// Stream bundle for the weighted round-robin packet arbiter.
// The slave modport is the arbiter's own view. The master modport is the
// surrounding environment that feeds the requesters and sinks the output.
interface wrr_packet_arbiter_if #(
    parameter int S_DATA_COUNT = 4,
    parameter int T_DATA_WIDTH = 32,
    parameter int WEIGHT_WIDTH = 4
);
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT);

    logic [S_DATA_COUNT-1:0]                   s_valid_i;
    logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i;
    logic [S_DATA_COUNT-1:0]                   s_last_i;
    logic [S_DATA_COUNT-1:0]                   s_ready_o;
    logic [S_DATA_COUNT-1:0][WEIGHT_WIDTH-1:0] weight_i;
    logic                                      m_valid_o;
    logic [T_DATA_WIDTH-1:0]                   m_data_o;
    logic                                      m_last_o;
    logic [T_ID___WIDTH-1:0]                   m_id_o;
    logic                                      m_ready_i;
    logic                                      busy_o;

    modport slave (
        input  s_valid_i, s_data_i, s_last_i, weight_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o, m_last_o, m_id_o, busy_o
    );

    modport master (
        output s_valid_i, s_data_i, s_last_i, weight_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o, m_last_o, m_id_o, busy_o
    );
endinterface

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin packet arbiter.
// A requester wins a grant for one whole packet. After a win it may keep
// winning back-to-back for up to its weight in packets, as long as it stays
// valid; otherwise the grant rotates to the next valid requester above the
// current owner. The owner's stream is passed straight through to the output,
// with one idle cycle between packets in which the next grant is decided.
module wrr_packet_arbiter #(
    parameter int S_DATA_COUNT = 4,
    parameter int T_DATA_WIDTH = 32,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_in,
    wrr_packet_arbiter_if.slave bus
);
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT);
    localparam int SUM_WIDTH    = T_ID___WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [T_ID___WIDTH-1:0] owner_q, owner_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

    logic                    last_beat;
    logic                    found;
    logic [SUM_WIDTH-1:0]    sum;
    logic [T_ID___WIDTH-1:0] cand;

    // The packet ends on the handshake of the owner's beat that carries last.
    always_comb begin
        last_beat = (state_q == BUSY) && bus.s_valid_i[owner_q] &&
                    bus.m_ready_i && bus.s_last_i[owner_q];
    end

    // Next grant: a still-valid owner with credit left keeps the grant,
    // otherwise rotate upward from owner+1, visiting the owner itself last.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        credit_d = credit_q;
        found    = 1'b0;
        sum      = '0;
        cand     = '0;
        case (state_q)
            IDLE: begin
                if (|bus.s_valid_i) begin
                    state_d = BUSY;
                    if ((credit_q != '0) && bus.s_valid_i[owner_q]) begin
                        credit_d = credit_q - WEIGHT_WIDTH'(1);
                    end else begin
                        for (int k = 1; k <= S_DATA_COUNT; k++) begin
                            sum = {1'b0, owner_q} + SUM_WIDTH'(k);
                            if (sum >= SUM_WIDTH'(S_DATA_COUNT)) begin
                                sum = sum - SUM_WIDTH'(S_DATA_COUNT);
                            end
                            cand = sum[T_ID___WIDTH-1:0];
                            if (!found && bus.s_valid_i[cand]) begin
                                found   = 1'b1;
                                owner_d = cand;
                                if (bus.weight_i[cand] == '0) begin
                                    credit_d = '0;
                                end else begin
                                    credit_d = bus.weight_i[cand] - WEIGHT_WIDTH'(1);
                                end
                            end
                        end
                    end
                end
            end
            BUSY: begin
                if (last_beat) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant state; reset drops any packet in flight and parks the owner at
    // the top index so the first rotation after reset starts at requester 0.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            owner_q  <= T_ID___WIDTH'(S_DATA_COUNT - 1);
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
        end
    end

    // Pass-through of the owner's stream while busy; everything quiet in idle.
    always_comb begin
        bus.s_ready_o = '0;
        bus.m_valid_o = 1'b0;
        bus.m_last_o  = 1'b0;
        bus.m_data_o  = '0;
        bus.m_id_o    = owner_q;
        bus.busy_o    = (state_q == BUSY);
        if (state_q == BUSY) begin
            bus.m_valid_o          = bus.s_valid_i[owner_q];
            bus.m_last_o           = bus.s_last_i[owner_q];
            bus.m_data_o           = bus.s_data_i[owner_q];
            bus.s_ready_o[owner_q] = bus.m_ready_i;
        end
    end
endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Testbench for the weighted round-robin packet arbiter.
module tb_wrr_packet_arbiter;
    localparam int S  = 4;
    localparam int DW = 32;
    localparam int WW = 4;

    logic clk;
    logic rst_n;

    wrr_packet_arbiter_if #(.S_DATA_COUNT(S), .T_DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) bus ();

    wrr_packet_arbiter #(.S_DATA_COUNT(S), .T_DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
        .clk_i (clk),
        .rst_in(rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  l;
        logic        rdy;
        logic [15:0] w;
        logic        ev;
        logic        el;
        int          eid;
        logic        eb;
        logic [3:0]  er;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[14];

    int checks = 0;
    int errors = 0;
    int md_busy;
    int md_owner;
    int md_credit;
    int grant_log[$];
    int beat_cnt;
    logic prev_busy;
    logic [15:0] wcur;

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected to finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        md_busy   = 0;
        md_owner  = S - 1;
        md_credit = 0;
    endfunction

    // Behavioural reference: owner/credit bookkeeping with modulo rotation.
    task automatic model_step();
        int eff;
        int j;
        if (!rst_n) begin
            model_reset();
        end else if (md_busy == 0) begin
            if (bus.s_valid_i != 4'b0) begin
                if (md_credit != 0 && bus.s_valid_i[2'(md_owner)]) begin
                    md_credit = md_credit - 1;
                end else begin
                    for (int k = 1; k <= S; k++) begin
                        j = (md_owner + k) % S;
                        if (bus.s_valid_i[2'(j)]) begin
                            eff = int'(bus.weight_i[2'(j)]);
                            if (eff == 0) eff = 1;
                            md_owner  = j;
                            md_credit = eff - 1;
                            break;
                        end
                    end
                end
                md_busy = 1;
            end
        end else begin
            if (bus.s_valid_i[2'(md_owner)] && bus.m_ready_i && bus.s_last_i[2'(md_owner)]) begin
                md_busy = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [3:0] l,
                                 input logic rdy, input logic [15:0] w, input logic [31:0] base);
        rst_n         = r;
        bus.s_valid_i = v;
        bus.s_last_i  = l;
        bus.m_ready_i = rdy;
        bus.weight_i  = w;
        for (int j = 0; j < S; j++) begin
            bus.s_data_i[j] = base + 32'(j);
        end
        if (!r) model_reset();
    endtask

    task automatic checkOutput();
        logic [1:0] oi;
        oi = 2'(md_owner);
        checkVal("busy_o", 32'(bus.busy_o), 32'(md_busy != 0));
        checkVal("m_id_o", 32'(bus.m_id_o), 32'(oi));
        if (md_busy != 0) begin
            checkVal("m_valid_o", 32'(bus.m_valid_o), 32'(bus.s_valid_i[oi]));
            checkVal("m_last_o", 32'(bus.m_last_o), 32'(bus.s_last_i[oi]));
            checkVal("m_data_o", bus.m_data_o, bus.s_data_i[oi]);
            checkVal("s_ready_o", 32'(bus.s_ready_o), 32'(4'(bus.m_ready_i) << oi));
        end else begin
            checkVal("m_valid_o_idle", 32'(bus.m_valid_o), 32'd0);
            checkVal("m_last_o_idle", 32'(bus.m_last_o), 32'd0);
            checkVal("m_data_o_idle", bus.m_data_o, 32'd0);
            checkVal("s_ready_o_idle", 32'(bus.s_ready_o), 32'd0);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        checkOutput();
        if (bus.busy_o && !prev_busy) grant_log.push_back(int'(bus.m_id_o));
        if (bus.busy_o && bus.m_valid_o && bus.m_ready_i) beat_cnt++;
        prev_busy = bus.busy_o;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic doReset(input logic [15:0] w);
        wcur = w;
        applyStimulus(1'b0, 4'b0, 4'b0, 1'b1, w, 32'h0);
        cycle();
        applyStimulus(1'b1, 4'b0, 4'b0, 1'b1, w, 32'h0);
        cycle();
        grant_log.delete();
    endtask

    task automatic checkGrants(input string name, input int exp[]);
        checkVal({name, "_count"}, 32'(grant_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < grant_log.size()) checkVal({name, "_grant"}, 32'(grant_log[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        int exp_a[];
        int exp_c[];
        int exp_d[];
        logic [3:0] v;
        logic [3:0] l;
        logic rdy;

        prev_busy = 1'b0;
        beat_cnt  = 0;
        model_reset();

        // rst, v, l, rdy, w, ev, el, eid, eb, er, ed
        tbl[0]  = '{1'b0, 4'b1010, 4'b1111, 1'b1, 16'h1111, 1'b0, 1'b0, 3, 1'b0, 4'b0000, 32'h0};
        tbl[1]  = '{1'b1, 4'b1010, 4'b1111, 1'b1, 16'h1111, 1'b0, 1'b0, 3, 1'b0, 4'b0000, 32'h0};
        tbl[2]  = '{1'b1, 4'b1010, 4'b1111, 1'b1, 16'h1111, 1'b1, 1'b1, 1, 1'b1, 4'b0010, 32'hD0000001};
        tbl[3]  = '{1'b1, 4'b1010, 4'b1111, 1'b1, 16'h1111, 1'b0, 1'b0, 1, 1'b0, 4'b0000, 32'h0};
        tbl[4]  = '{1'b1, 4'b1010, 4'b1111, 1'b1, 16'h1111, 1'b1, 1'b1, 3, 1'b1, 4'b1000, 32'hD0000003};
        tbl[5]  = '{1'b1, 4'b1010, 4'b1111, 1'b1, 16'h1111, 1'b0, 1'b0, 3, 1'b0, 4'b0000, 32'h0};
        tbl[6]  = '{1'b1, 4'b1010, 4'b1111, 1'b1, 16'h1111, 1'b1, 1'b1, 1, 1'b1, 4'b0010, 32'hD0000001};
        tbl[7]  = '{1'b0, 4'b0011, 4'b1111, 1'b1, 16'h1101, 1'b0, 1'b0, 3, 1'b0, 4'b0000, 32'h0};
        tbl[8]  = '{1'b1, 4'b0011, 4'b1111, 1'b1, 16'h1101, 1'b0, 1'b0, 3, 1'b0, 4'b0000, 32'h0};
        tbl[9]  = '{1'b1, 4'b0011, 4'b1111, 1'b1, 16'h1101, 1'b1, 1'b1, 0, 1'b1, 4'b0001, 32'hD0000000};
        tbl[10] = '{1'b1, 4'b0011, 4'b1111, 1'b1, 16'h1101, 1'b0, 1'b0, 0, 1'b0, 4'b0000, 32'h0};
        tbl[11] = '{1'b1, 4'b0011, 4'b1111, 1'b1, 16'h1101, 1'b1, 1'b1, 1, 1'b1, 4'b0010, 32'hD0000001};
        tbl[12] = '{1'b1, 4'b0011, 4'b1111, 1'b1, 16'h1101, 1'b0, 1'b0, 1, 1'b0, 4'b0000, 32'h0};
        tbl[13] = '{1'b1, 4'b0011, 4'b1111, 1'b1, 16'h1101, 1'b1, 1'b1, 0, 1'b1, 4'b0001, 32'hD0000000};

        $display("[TB] table vectors");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].rdy, tbl[i].w, 32'hD0000000);
            @(negedge clk);
            checkVal("tbl_m_valid", 32'(bus.m_valid_o), 32'(tbl[i].ev));
            checkVal("tbl_m_last", 32'(bus.m_last_o), 32'(tbl[i].el));
            checkVal("tbl_m_id", 32'(bus.m_id_o), 32'(tbl[i].eid));
            checkVal("tbl_busy", 32'(bus.busy_o), 32'(tbl[i].eb));
            checkVal("tbl_s_ready", 32'(bus.s_ready_o), 32'(tbl[i].er));
            checkVal("tbl_m_data", bus.m_data_o, tbl[i].ed);
            prev_busy = bus.busy_o;
            @(posedge clk);
            model_step();
            #1;
        end

        $display("[TB] weighted sequence 0,3,3,3");
        doReset(16'h3111);
        applyStimulus(1'b1, 4'b1001, 4'b1001, 1'b1, wcur, 32'h11110000);
        repeat (16) cycle();
        exp_a = '{0, 3, 3, 3, 0, 3, 3, 3};
        checkGrants("weighted", exp_a);

        $display("[TB] multi-beat packet with gaps");
        doReset(16'h1111);
        applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b1, wcur, 32'h22220000);
        cycle();
        beat_cnt = 0;
        for (int c = 0; c < 60 && beat_cnt < 4; c++) begin
            rdy  = c[0];
            v    = {1'b1, ($urandom_range(0, 2) != 0), 2'b11};
            l    = {1'b1, (beat_cnt == 3), 2'b11};
            applyStimulus(1'b1, v, l, rdy, wcur, $urandom);
            cycle();
        end
        checkVal("beats_out", 32'(beat_cnt), 32'd4);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, wcur, 32'h0);
        cycle();
        checkVal("grant_after_packet", 32'(grant_log.size()), 32'd1);

        $display("[TB] asynchronous reset mid-packet");
        doReset(16'h5111);
        applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b1, wcur, 32'h33330000);
        cycle();
        cycle();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checkVal("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
        checkVal("rst_s_ready", 32'(bus.s_ready_o), 32'd0);
        checkVal("rst_busy", 32'(bus.busy_o), 32'd0);
        checkVal("rst_m_last", 32'(bus.m_last_o), 32'd0);
        checkVal("rst_m_data", bus.m_data_o, 32'd0);
        checkVal("rst_m_id", 32'(bus.m_id_o), 32'd3);
        @(posedge clk);
        #2;
        grant_log.delete();
        applyStimulus(1'b1, 4'b1000, 4'b1111, 1'b1, wcur, 32'h44440000);
        cycle();
        cycle();
        applyStimulus(1'b1, 4'b1001, 4'b1111, 1'b1, wcur, 32'h55550000);
        repeat (10) cycle();
        exp_c = '{3, 3, 3, 3, 3, 0};
        checkGrants("reset_reload", exp_c);

        $display("[TB] owner drops with credit left");
        doReset(16'h1231);
        applyStimulus(1'b1, 4'b0010, 4'b1111, 1'b1, wcur, 32'h66660000);
        repeat (2) cycle();
        applyStimulus(1'b1, 4'b0100, 4'b1111, 1'b1, wcur, 32'h77770000);
        repeat (2) cycle();
        applyStimulus(1'b1, 4'b0110, 4'b1111, 1'b1, wcur, 32'h88880000);
        repeat (4) cycle();
        exp_d = '{1, 2, 2, 1};
        checkGrants("drop_credit", exp_d);

        $display("[TB] randomized traffic against reference model");
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom_range(0, 199) != 0), 4'($urandom), 4'($urandom),
                          ($urandom_range(0, 3) != 0), 16'($urandom), $urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
